// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder sequencer.
// The slave side is the sequencer; the master side offers operands and takes results.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Drives an external 4-bit adder slice one nibble per clock, LSB first,
// chaining carry through carry_q and presenting the wide sum on a handshake.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    nibble_serial_adder_ctrl_if.slave     bus,
    output logic [3:0]                    add_a,
    output logic [3:0]                    add_b,
    output logic                          add_cin,
    input  logic [3:0]                    add_sum,
    input  logic                          add_cout,
    output logic                          busy
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NIBBLES-1:0][3:0]    a_q, a_d;
    logic [NIBBLES-1:0][3:0]    b_q, b_d;
    logic [NIBBLES-1:0][3:0]    sum_q, sum_d;
    logic                       carry_q, carry_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       in_ready_c;
    logic                       out_valid_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        add_a       = 4'h0;
        add_b       = 4'h0;
        add_cin     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_cin = carry_q;
                // Explicit decode keeps the nibble select in range for any NIBBLES.
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IW'(n)) begin
                        add_a    = a_q[n];
                        add_b    = b_q[n];
                        sum_d[n] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == IW'(NIBBLES - 1)) state_d = DONE;
                else                          idx_d   = idx_q + IW'(1);
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = carry_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for the nibble-serial adder sequencer: directed corner cases plus a
// randomized stream compared against plain a+b+cin, for NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder_ctrl;
    localparam int N  = 4;
    localparam int W  = 4 * N;
    localparam int W1 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout, busy;
    logic [3:0] add1_a, add1_b, add1_sum;
    logic       add1_cin, add1_cout, busy1;

    // Behavioural stand-ins for the external ripple-carry slices.
    assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign {add1_cout, add1_sum} = {1'b0, add1_a} + {1'b0, add1_b} + {4'b0, add1_cin};

    nibble_serial_adder_ctrl #(.NIBBLES(N)) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .add_a(add1_a), .add_b(add1_b), .add_cin(add1_cin),
        .add_sum(add1_sum), .add_cout(add1_cout), .busy(busy1)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] cap_a [N];
    logic       cap_cin [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one pair from IDLE (at a negedge), track the RUN cycles, stop in DONE.
    task automatic op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        check("op_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = cin;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("run_out_valid", bus.out_valid, 0);
            check("run_in_ready", bus.in_ready, 0);
            cap_a[i]   = add_a;
            cap_cin[i] = add_cin;
            @(negedge clk);
        end
        check("latency_out_valid", bus.out_valid, 1);
        check("op_result", {bus.out_cout, bus.out_sum}, {1'b0, a} + {1'b0, b} + cin);
    endtask

    task automatic retire4();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("retire_busy", busy, 0);
        check("retire_in_ready", bus.in_ready, 1);
        check("retire_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        logic [16:0] q [$];
        logic [4:0]  q1 [$];
        logic [W-1:0] ra, rb;
        logic [W1-1:0] ra1, rb1;
        logic rc, rc1;
        int done, cyc;

        rst = 1'b1;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_cin = 0; bus.out_ready = 0;
        bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0; bus1.in_cin = 0; bus1.out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_out_sum", bus.out_sum, 0);
        check("idle_out_cout", bus.out_cout, 0);
        check("idle_add_a", add_a, 0);
        check("idle_add_b", add_b, 0);
        check("idle_add_cin", add_cin, 0);

        // Full carry chain
        op4(16'hFFFF, 16'h0001, 1'b0);
        check("chain_sum", bus.out_sum, 16'h0000);
        check("chain_cout", bus.out_cout, 1);
        for (int i = 0; i < N; i++) check("chain_add_cin", cap_cin[i], (i == 0) ? 0 : 1);
        retire4();

        // Carry-in and nibble ordering
        op4(16'h1234, 16'h4321, 1'b1);
        check("cin_sum", bus.out_sum, 16'h5556);
        check("cin_cout", bus.out_cout, 0);
        for (int i = 0; i < N; i++) check("cin_add_a", cap_a[i], 4 - i);
        retire4();

        // Back-pressure with ignored offers
        op4(16'hABCD, 16'h1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.in_a = W'($urandom); bus.in_b = W'($urandom); bus.in_cin = 1'($urandom);
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_sum", bus.out_sum, 16'hBCDE);
            check("bp_out_cout", bus.out_cout, 0);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        retire4();
        op4(16'h0F0F, 16'h00F1, 1'b0);
        check("bp_next_sum", bus.out_sum, 16'h1000);
        retire4();

        // Reset two cycles into RUN
        bus.in_valid = 1'b1; bus.in_a = 16'h1111; bus.in_b = 16'h2222; bus.in_cin = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_partial", bus.out_sum, 16'h0033);
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", bus.out_sum, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_valid", bus.out_valid, 0);
        op4(16'h00FF, 16'h0001, 1'b0);
        check("post_abort_sum", bus.out_sum, 16'h0100);
        check("post_abort_cout", bus.out_cout, 0);
        retire4();

        // Random stream, NIBBLES=4
        done = 0; cyc = 0;
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        while (done < 1000 && cyc < 40000) begin
            bus.in_valid = 1'b1; bus.in_a = ra; bus.in_b = rb; bus.in_cin = rc;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("rand_spurious_valid", 1, 0);
                else check("rand_result", {bus.out_cout, bus.out_sum}, q.pop_front());
                done++;
            end
            if (bus.in_ready) begin
                check("rand_no_overlap", q.size(), 0);
                q.push_back({1'b0, ra} + {1'b0, rb} + rc);
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check("rand_done", done, 1000);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (N + 2) @(negedge clk);
        bus.out_ready = 1'b0;

        // NIBBLES=1 directed
        bus1.in_valid = 1'b1; bus1.in_a = 4'hF; bus1.in_b = 4'h1; bus1.in_cin = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check("n1_run_add_a", add1_a, 4'hF);
        check("n1_run_out_valid", bus1.out_valid, 0);
        @(negedge clk);
        check("n1_out_valid", bus1.out_valid, 1);
        check("n1_sum", bus1.out_sum, 4'h1);
        check("n1_cout", bus1.out_cout, 1);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check("n1_idle", bus1.in_ready, 1);

        // Random stream, NIBBLES=1
        done = 0; cyc = 0;
        ra1 = W1'($urandom); rb1 = W1'($urandom); rc1 = 1'($urandom);
        while (done < 300 && cyc < 10000) begin
            bus1.in_valid = 1'b1; bus1.in_a = ra1; bus1.in_b = rb1; bus1.in_cin = rc1;
            bus1.out_ready = ($urandom_range(0, 3) != 0);
            if (bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) check("n1_rand_spurious_valid", 1, 0);
                else check("n1_rand_result", {bus1.out_cout, bus1.out_sum}, q1.pop_front());
                done++;
            end
            if (bus1.in_ready) begin
                check("n1_rand_no_overlap", q1.size(), 0);
                q1.push_back({1'b0, ra1} + {1'b0, rb1} + rc1);
                ra1 = W1'($urandom); rb1 = W1'($urandom); rc1 = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check("n1_rand_done", done, 300);
        bus1.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing stage that wraps the team's 4-bit ripple-carry adder slice to perform wide additions one nibble per clock. It accepts a wide operand pair over a valid/ready handshake and drives the adder slice's a/b/cin inputs nibble by nibble, LSB first. It captures the slice's sum/carry outputs into a result register, chaining carry between nibbles. It then presents the wide sum and final carry on a valid/ready output handshake.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry into nibble 0
- add_a  output  4  to adder slice a
- add_b  output  4  to adder slice b
- add_cin  output  1  to adder slice cin
- add_sum  input  4  from adder slice sum (combinational response to add_a/add_b/add_cin)
- add_cout  input  1  from adder slice cout
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  W  wide sum
- out_cout  output  1  carry out of top nibble
- busy  output  1  high in RUN or DONE

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On clk edge with in_valid=1: latch in_a/in_b into a_reg/b_reg; carry_reg<=in_cin; idx<=0; sum_reg<=0; go to RUN.
- RUN:
  - in_ready=0.
  - add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry_reg.
  - Each edge: sum_reg[4*idx+:4]<=add_sum; carry_reg<=add_cout.
  - If idx==NIBBLES-1, go to DONE; else idx<=idx+1.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_cout=carry_reg.
  - Held stable until an edge with out_ready=1, then go to IDLE.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- out_sum and out_cout reflect the registers in all states, but are meaningful only while out_valid=1.
- No overlap: a new operand pair is accepted only in IDLE. in_valid in RUN/DONE is ignored, and nothing is queued.
- idx width: clog2(NIBBLES), minimum 1 bit.
- Arithmetic is unsigned modulo 2^W; out_cout is the carry out of bit W-1.

## Timing
- Reset (async assert, any time):
  - State IDLE; a_reg, b_reg, sum_reg, carry_reg, idx all 0.
  - Outputs: out_valid=0, busy=0, out_sum=0, out_cout=0, add_*=0.
  - in_ready=1, but no acceptance occurs while rst=1.
- Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded. No out_valid is produced for the aborted operation.
- Latency: operands accepted at edge E0; out_valid rises after edge E0+NIBBLES, i.e. it is visible in the cycle following that edge.
- Throughput: one result per NIBBLES+2 cycles when out_ready is held high. Breakdown: NIBBLES RUN cycles, 1 DONE cycle, 1 IDLE cycle.
- The adder slice path is combinational within one cycle; registers sample add_sum/add_cout at the end of each RUN cycle.
- Back-pressure: out_ready=0 in DONE holds out_valid, out_sum and out_cout stable indefinitely.
- NIBBLES=1: RUN lasts exactly one cycle; behaviour is otherwise identical.

## Test plan
- Reset then idle: after rst deasserts, in_ready=1, out_valid=0, busy=0, out_sum=0, add_a=add_b=0.
- Full carry chain (NIBBLES=4):
  - Stimulus: in_a=0xFFFF, in_b=0x0001, in_cin=0.
  - Required: out_sum=0x0000, out_cout=1, out_valid exactly 4 edges after acceptance.
  - Required: add_cin sequence 0,1,1,1 across RUN cycles.
- Carry-in use:
  - Stimulus: 0x1234 + 0x4321 with in_cin=1.
  - Required: out_sum=0x5556, out_cout=0; add_a sequence 4,3,2,1 across RUN cycles.
- Back-pressure and ignored input:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands.
  - Required: result held stable, in_ready=0 throughout, new operands not taken.
  - Required: after out_ready=1, state is IDLE next cycle and the next offer is accepted.
- Reset mid-RUN:
  - Stimulus: assert rst after 2 RUN cycles.
  - Required: immediate out_valid=0, busy=0, sum_reg=0.
  - Required: a following 0x00FF + 0x0001 operation yields 0x0100, cout 0.
- Random regression: 1000 back-to-back operands with random out_ready stalls, checked against a+b+cin; also run with NIBBLES=1 (e.g. 0xF+0x1+1 -> sum 0x1, cout 1).
